// File: rtl/ahb_wb_pkg.sv
// Shared constants, state encoding and byte-lane helper for the AHB-Lite to
// Wishbone bridge.
package ahb_wb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    RESP,
    ERR1,
    ERR2
  } state_t;

  // Byte-lane mask for a transfer of 2**size bytes at the given address,
  // aligned down to the size boundary. Returned in 8 bits; callers keep the
  // low 'lanes' bits.
  function automatic logic [7:0] byte_sel(input logic [2:0] size,
                                          input logic [2:0] addr_lsbs,
                                          input int         lanes);
    int          nbytes;
    int          offset;
    logic [15:0] mask;
    nbytes = 1 << size;
    offset = (int'(addr_lsbs) % lanes) & ~(nbytes - 1);
    mask   = 16'((1 << nbytes) - 1) << offset;
    return mask[7:0];
  endfunction

endpackage

// File: rtl/ahb_wb_timeout.sv
// Wishbone wait-cycle watchdog: counts enabled cycles since the last clear and
// flags the cycle in which the TIMEOUT_CYCLES-th wait cycle is reached.
// A TIMEOUT_CYCLES of 0 removes the counter entirely.
module ahb_wb_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_cnt
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

      logic [CW-1:0] r_cnt;

      // Count wait cycles; cleared whenever the bridge is not waiting on Wishbone.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_cnt <= '0;
        end else if (i_clr) begin
          r_cnt <= '0;
        end else if (i_en) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      // Expired during the last permitted wait cycle so the bridge leaves
      // ACCESS exactly TIMEOUT_CYCLES cycles after entering it.
      assign o_expired = i_en && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    end else begin : g_off
      logic w_unused_ctl;
      assign w_unused_ctl = ^{i_clk, i_rst_n, i_clr, i_en};
      assign o_expired    = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/ahb_wb_bridge.sv
// AHB-Lite slave to Wishbone classic master bridge. Each accepted AHB beat
// becomes one Wishbone cycle; Wishbone errors, timeouts and oversize
// transfers are reported with the two-cycle AHB ERROR response.
module ahb_wb_bridge
  import ahb_wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HSEL,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  input  logic                    HREADY,
  output logic [DATA_WIDTH-1:0]   HRDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic                    wb_cyc,
  output logic                    wb_stb,
  output logic                    wb_we,
  output logic [ADDR_WIDTH-1:0]   wb_adr,
  output logic [DATA_WIDTH/8-1:0] wb_sel,
  output logic [DATA_WIDTH-1:0]   wb_dat_w,
  input  logic [DATA_WIDTH-1:0]   wb_dat_r,
  input  logic                    wb_ack,
  input  logic                    wb_err
);

  localparam int LANES     = DATA_WIDTH / 8;
  localparam int LANE_LOG2 = $clog2(LANES);

  state_t r_state;
  logic   w_accept;
  logic   w_legal;
  logic   w_tmo_clr;
  logic   w_tmo_en;
  logic   w_tmo_expired;
  logic   w_unused_bits;

  // Bursts are split into independent beats and only HTRANS[1] qualifies a
  // transfer, so these inputs carry no information for the bridge.
  assign w_unused_bits = ^{HBURST, HTRANS[0]};

  assign w_accept = HSEL & HTRANS[1] & HREADY;
  assign w_legal  = (HSIZE <= 3'(LANE_LOG2));

  // HWDATA belongs to the data phase and is held by the master while
  // HREADYOUT is low, so it can drive the Wishbone write bus directly.
  assign wb_dat_w = HWDATA;

  // Counter is held at zero outside ACCESS, which clears it on every entry.
  assign w_tmo_en  = (r_state == ACCESS);
  assign w_tmo_clr = (r_state != ACCESS);

  ahb_wb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (HCLK),
    .i_rst_n  (HRESETn),
    .i_clr    (w_tmo_clr),
    .i_en     (w_tmo_en),
    .o_expired(w_tmo_expired)
  );

  // Bridge FSM with registered AHB response and Wishbone request outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state   <= IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      HRDATA    <= '0;
      wb_cyc    <= 1'b0;
      wb_stb    <= 1'b0;
      wb_we     <= 1'b0;
      wb_adr    <= '0;
      wb_sel    <= '0;
    end else begin
      case (r_state)
        // Every state with HREADYOUT high can take a new address phase.
        IDLE, RESP, ERR2: begin
          if (w_accept && w_legal) begin
            r_state   <= ACCESS;
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_OKAY;
            wb_cyc    <= 1'b1;
            wb_stb    <= 1'b1;
            wb_we     <= HWRITE;
            wb_adr    <= HADDR;
            wb_sel    <= LANES'(byte_sel(HSIZE, HADDR[2:0], LANES));
          end else if (w_accept) begin
            r_state   <= ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_ERROR;
          end else begin
            r_state   <= IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
          end
        end
        // Error beats ack; ack beats a timeout landing in the same cycle.
        ACCESS: begin
          if (wb_err) begin
            r_state   <= ERR1;
            HRESP     <= HRESP_ERROR;
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
          end else if (wb_ack) begin
            r_state   <= RESP;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            if (!wb_we) begin
              HRDATA <= wb_dat_r;
            end
          end else if (w_tmo_expired) begin
            r_state   <= ERR1;
            HRESP     <= HRESP_ERROR;
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
          end
        end
        ERR1: begin
          r_state   <= ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_ERROR;
        end
        default: begin
          r_state   <= IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_wb_bridge.sv
// Scoreboard bench for ahb_wb_bridge (32-bit data, 4-cycle timeout).
module tb_ahb_wb_bridge;

  localparam int TMO = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  wire         HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_w;
  logic [31:0] wb_dat_r;
  logic        wb_ack, wb_err;

  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  ahb_wb_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_sel(wb_sel), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r),
    .wb_ack(wb_ack), .wb_err(wb_err)
  );

  // mode: 0 ack, 1 err, 2 ack+err together, 3 slave never answers
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          mode;
    int          delay;
  } tr_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } ahb_exp_t;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdata;
    int          mode;
    int          delay;
  } wb_exp_t;

  ahb_exp_t    ahb_q[$];
  wb_exp_t     wb_q[$];
  logic [7:0]  ref_mem [0:63];
  logic [31:0] last_rd;
  logic [31:0] slv_mem [0:15];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Lanes touched: the naturally aligned 2**size-byte block holding addr.
  function automatic logic [3:0] lanes_of(input logic [31:0] addr, input logic [2:0] size);
    int         n;
    logic [3:0] s;
    n = 1 << size;
    s = '0;
    for (int b = 0; b < 4; b++)
      if (b / n == int'(addr[1:0]) / n) s[b] = 1'b1;
    return s;
  endfunction

  // Reference model: byte memory plus "last read data" for HRDATA hold.
  task automatic model_push(input tr_t t);
    ahb_exp_t   a;
    wb_exp_t    w;
    logic [3:0] s;
    logic       legal;
    int         base;
    legal = (t.size <= 3'd2);
    s     = lanes_of(t.addr, t.size);
    base  = int'(t.addr - 32'h100) & ~3;
    a.err = !legal || (t.mode != 0);
    if (!a.err) begin
      if (t.wr) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[base + b] = t.wdata[8*b +: 8];
      end else begin
        last_rd = {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
      end
    end
    a.rdata = last_rd;
    ahb_q.push_back(a);
    if (legal) begin
      w.adr = t.addr; w.sel = s; w.we = t.wr; w.wdata = t.wdata;
      w.mode = t.mode; w.delay = t.delay;
      wb_q.push_back(w);
    end
  endtask

  task automatic wait_ready();
    int g;
    g = 0;
    while (!HREADYOUT && g < 100) begin
      @(posedge HCLK); #1;
      g++;
    end
    if (g >= 100) bound_fail("hreadyout_wait");
  endtask

  // Present one address phase (real transfer or one of the no-op kinds),
  // wait for it to be taken, then drive its data phase.
  task automatic issue(input tr_t t, input logic real_tr, input int idle_kind);
    HBURST = 3'($urandom_range(0, 7));
    if (real_tr) begin
      HSEL   = 1'b1;
      HTRANS = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b10;
      HADDR  = t.addr;
      HWRITE = t.wr;
      HSIZE  = t.size;
      model_push(t);
    end else begin
      HADDR  = 32'h100 + 32'($urandom_range(0, 63));
      HWRITE = 1'($urandom_range(0, 1));
      HSIZE  = 3'($urandom_range(0, 3));
      case (idle_kind)
        0:       begin HSEL = 1'b1; HTRANS = 2'b00; end
        1:       begin HSEL = 1'b1; HTRANS = 2'b01; end
        default: begin HSEL = 1'b0; HTRANS = 2'b10; end
      endcase
    end
    wait_ready();
    @(posedge HCLK); #1;
    HWDATA = (real_tr && t.wr) ? t.wdata : $urandom;
  endtask

  task automatic drain();
    tr_t t;
    int  g;
    t = '{32'h100, 1'b0, 3'd0, 32'h0, 0, 0};
    g = 0;
    while (ahb_q.size() != 0 && g < 200) begin
      issue(t, 1'b0, 0);
      g++;
    end
    if (g >= 200) bound_fail("drain");
    issue(t, 1'b0, 0);
    issue(t, 1'b0, 0);
  endtask

  function automatic tr_t rand_tr();
    tr_t t;
    int  r;
    t.addr  = 32'h100 + 32'($urandom_range(0, 63));
    t.wr    = 1'($urandom_range(0, 1));
    r       = $urandom_range(0, 7);
    t.size  = (r < 7) ? 3'(r % 3) : 3'd3;
    t.wdata = $urandom;
    r       = $urandom_range(0, 9);
    t.mode  = (r < 7) ? 0 : r - 6;
    t.delay = $urandom_range(0, 2);
    return t;
  endfunction

  // AHB response monitor: pops an expectation whenever a data phase ends.
  logic in_dp, prev_rdy, prev_resp;
  initial begin
    ahb_exp_t e;
    in_dp = 1'b0; prev_rdy = 1'b1; prev_resp = 1'b0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        in_dp = 1'b0; prev_rdy = 1'b1; prev_resp = 1'b0;
      end else begin
        if (HREADYOUT) begin
          if (in_dp) begin
            if (ahb_q.size() == 0) begin
              bound_fail("ahb_unexpected_response");
            end else begin
              e = ahb_q.pop_front();
              chk("hresp", 32'(HRESP), 32'(e.err));
              chk("hrdata", HRDATA, e.rdata);
              if (e.err) chk("err_first_cycle", {30'd0, prev_rdy, prev_resp}, 32'd1);
              else       chk("okay_wait_state", 32'(prev_rdy), 32'd0);
            end
          end
          in_dp = HSEL && HTRANS[1];
        end
        prev_rdy  = HREADYOUT;
        prev_resp = HRESP;
      end
    end
  end

  // Wishbone slave: checks each request against the queue and answers it.
  initial begin
    wb_exp_t cur;
    logic    busy, chk_drop;
    int      cnt, cyc_n, idx;
    logic [31:0] m;
    busy = 1'b0; chk_drop = 1'b0; cnt = 0; cyc_n = 0;
    wb_ack = 1'b0; wb_err = 1'b0; wb_dat_r = '0;
    forever begin
      @(posedge HCLK); #2;
      wb_ack = 1'b0; wb_err = 1'b0; wb_dat_r = $urandom;
      if (!HRESETn) begin
        busy = 1'b0; chk_drop = 1'b0;
      end else if (chk_drop) begin
        chk("wb_cyc_drop", 32'(wb_cyc), 32'd0);
        chk_drop = 1'b0;
      end else if (wb_cyc && wb_stb) begin
        if (!busy) begin
          if (wb_q.size() == 0) begin
            bound_fail("wb_unexpected_cycle");
          end else begin
            cur = wb_q.pop_front();
            busy = 1'b1; cnt = 0; cyc_n = 0;
            chk("wb_adr", wb_adr, cur.adr);
            chk("wb_sel", 32'(wb_sel), 32'(cur.sel));
            chk("wb_we", 32'(wb_we), 32'(cur.we));
          end
        end
        if (busy) begin
          cyc_n++;
          if (cur.mode != 3 && cnt == cur.delay) begin
            idx = int'((wb_adr - 32'h100) >> 2) & 15;
            for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{cur.sel[b]}};
            case (cur.mode)
              0: begin
                wb_ack = 1'b1;
                if (cur.we) begin
                  chk("wb_dat_w", wb_dat_w & m, cur.wdata & m);
                  slv_mem[idx] = (slv_mem[idx] & ~m) | (wb_dat_w & m);
                end else begin
                  wb_dat_r = slv_mem[idx];
                end
              end
              1:       wb_err = 1'b1;
              default: begin wb_ack = 1'b1; wb_err = 1'b1; end
            endcase
            busy = 1'b0; chk_drop = 1'b1;
          end
          cnt++;
        end
      end else if (busy) begin
        chk("timeout_cycles", 32'(cyc_n), 32'(TMO));
        chk("timeout_mode", 32'(cur.mode), 32'd3);
        busy = 1'b0;
      end
    end
  end

  // Stimulus.
  initial begin
    tr_t dir [8];
    tr_t t;
    HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0;
    HSIZE = 3'd0; HBURST = 3'd0; HWDATA = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) slv_mem[i] = 32'h0;
    last_rd = 32'h0;

    #12;
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_wb_cyc", 32'(wb_cyc), 32'd0);
    chk("rst_wb_stb", 32'(wb_stb), 32'd0);
    chk("rst_wb_we", 32'(wb_we), 32'd0);
    chk("rst_wb_adr", wb_adr, 32'd0);
    chk("rst_wb_sel", 32'(wb_sel), 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // Directed beats, issued back-to-back.
    dir[0] = '{32'h100, 1'b1, 3'd2, 32'hDEADBEEF, 0, 0};
    dir[1] = '{32'h100, 1'b0, 3'd2, 32'h0,        0, 1};
    dir[2] = '{32'h103, 1'b1, 3'd0, 32'hAB000000, 0, 0};
    dir[3] = '{32'h100, 1'b0, 3'd2, 32'h0,        0, 0};
    dir[4] = '{32'h104, 1'b0, 3'd2, 32'h0,        2, 1};
    dir[5] = '{32'h108, 1'b1, 3'd2, 32'h12345678, 3, 0};
    dir[6] = '{32'h10C, 1'b0, 3'd3, 32'h0,        0, 0};
    dir[7] = '{32'h102, 1'b0, 3'd1, 32'h0,        0, 2};
    foreach (dir[i]) issue(dir[i], 1'b1, 0);
    drain();

    // Randomized traffic with random no-op gaps.
    for (int i = 0; i < 80; i++) begin
      t = rand_tr();
      repeat ($urandom_range(0, 3) == 0 ? 1 : 0) issue(t, 1'b0, $urandom_range(0, 2));
      issue(t, 1'b1, 0);
    end
    drain();

    // Asynchronous reset while a Wishbone cycle is open.
    t = '{32'h110, 1'b0, 3'd2, 32'h0, 3, 0};
    issue(t, 1'b1, 0);
    HSEL = 1'b0; HTRANS = 2'b00;
    @(posedge HCLK); #3;
    chk("pre_rst_wb_cyc", 32'(wb_cyc), 32'd1);
    HRESETn = 1'b0;
    #1;
    chk("async_rst_wb_cyc", 32'(wb_cyc), 32'd0);
    chk("async_rst_wb_stb", 32'(wb_stb), 32'd0);
    chk("async_rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("async_rst_hresp", 32'(HRESP), 32'd0);
    ahb_q.delete();
    wb_q.delete();
    last_rd = 32'h0;
    @(posedge HCLK); @(posedge HCLK); #1;
    HRESETn = 1'b1;

    t = '{32'h100, 1'b0, 3'd2, 32'h0, 0, 0};
    issue(t, 1'b1, 0);
    for (int i = 0; i < 6; i++) begin
      t = rand_tr();
      issue(t, 1'b1, 0);
    end
    drain();

    chk("ahb_q_empty", 32'(ahb_q.size()), 32'd0);
    chk("wb_q_empty", 32'(wb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
